// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority-vote bit decisions.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial input, idles high
//   i_rdy      downstream ready
//   o_vld      received frame available (held until o_vld && i_rdy)
//   o_data     received data word, first bit on the line is bit 0
//   pc_pass    parity check result, valid with o_vld
//   frame_err  a stop bit was sampled low, valid with o_vld
//   break_det  one-cycle pulse when a break frame completes
//   overrun    sticky: a completed frame was dropped while output was held
//
// Handshake: o_vld rises the cycle after a frame completes and stays high,
// with o_data/pc_pass/frame_err stable, until a cycle where o_vld && i_rdy;
// that handshake takes effect at the next clock edge.
module uart_rx_os #(
  parameter int    DATA_WIDTH   = 8,
  parameter string PARITY_CHECK = "NONE",
  parameter int    STOP_BITS    = 1,
  parameter int    CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  i_rdy,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  pc_pass,
  output logic                  frame_err,
  output logic                  break_det,
  output logic                  overrun
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_dw
    $fatal(1, "uart_rx_os: DATA_WIDTH must be 5..9");
  end
  if (PARITY_CHECK != "NONE" && PARITY_CHECK != "ODD" && PARITY_CHECK != "EVEN") begin : g_bad_par
    $fatal(1, "uart_rx_os: PARITY_CHECK must be NONE, ODD or EVEN");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_rx_os: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 3 || CLKS_PER_BIT > 1024) begin : g_bad_cpb
    $fatal(1, "uart_rx_os: CLKS_PER_BIT must be 3..1024");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int MID   = CLKS_PER_BIT / 2;
  localparam bit PAR_EN  = (PARITY_CHECK != "NONE");
  localparam bit PAR_ODD = (PARITY_CHECK == "ODD");
  localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(MID);
  localparam logic [CNT_W-1:0] SMP_VOTE = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    rx_s1, rx_s2, rx_s3;
  logic [1:0]              fill_q;
  logic                    armed_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    samp_a, samp_b;
  logic [3:0]              bit_idx_q;
  logic                    stop_idx_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic                    par_q;
  logic                    stop_err_q;
  logic                    stop0_bad_q;

  logic vote, at_vote, fall, complete, is_brk, fin_ferr, fin_stop0_bad, fin_pc;

  // rx_s3 is the previous synchronized value, used only for edge detection.
  // armed_q blocks start detection until a genuine synchronized high has been
  // observed after reset (fill_q marks when rx_s2 holds a real pin sample), so
  // a line held low through reset release cannot fake a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_s3   <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & rx_s2);
    end
  end

  assign vote    = (samp_a & samp_b) | (samp_a & rx_s2) | (samp_b & rx_s2);
  assign at_vote = (cnt_q == SMP_VOTE);
  assign fall    = armed_q & rx_s3 & ~rx_s2;

  // Completion-time flags include the stop bit being voted this cycle.
  assign fin_ferr      = stop_err_q | ~vote;
  assign fin_stop0_bad = (stop_idx_q == 1'b0) ? ~vote : stop0_bad_q;
  assign fin_pc        = PAR_EN ? ((^shreg_q ^ par_q) == PAR_ODD) : 1'b1;
  assign is_brk        = (shreg_q == '0) && (!PAR_EN || !par_q) && fin_stop0_bad;

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      IDLE:     if (fall) state_d = START;
      START:    if (at_vote) state_d = vote ? IDLE : DATA;
      DATA:     if (at_vote && bit_idx_q == LAST_DATA) state_d = PAR_EN ? PARITY : STOP;
      PARITY:   if (at_vote) state_d = STOP;
      STOP: begin
        if (at_vote && stop_idx_q == LAST_STOP) begin
          complete = 1'b1;
          state_d  = is_brk ? BRK_WAIT : IDLE;
        end
      end
      BRK_WAIT: if (rx_s2) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Bit timing and shift datapath. The counter is held at 0 in IDLE so it
  // starts from 0 on the cycle the FSM enters START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      samp_a      <= 1'b1;
      samp_b      <= 1'b1;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      stop_err_q  <= 1'b0;
      stop0_bad_q <= 1'b0;
    end else begin
      if (state_q == IDLE)       cnt_q <= '0;
      else if (cnt_q == CNT_LAST) cnt_q <= '0;
      else                        cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == SMP_A) samp_a <= rx_s2;
      if (cnt_q == SMP_B) samp_b <= rx_s2;
      if (at_vote) begin
        case (state_q)
          START: begin
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            stop_err_q  <= 1'b0;
            stop0_bad_q <= 1'b0;
            par_q       <= 1'b0;
          end
          DATA: begin
            shreg_q   <= {vote, shreg_q[DATA_WIDTH-1:1]};
            bit_idx_q <= bit_idx_q + 4'd1;
          end
          PARITY: par_q <= vote;
          STOP: begin
            stop_idx_q  <= stop_idx_q + 1'b1;
            stop_err_q  <= fin_ferr;
            stop0_bad_q <= fin_stop0_bad;
          end
          default: ;
        endcase
      end
    end
  end

  // Output holding register. A frame completing while an un-acknowledged
  // frame is held is dropped; a same-cycle handshake frees the slot instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld     <= 1'b0;
      o_data    <= '0;
      pc_pass   <= 1'b1;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      break_det <= complete & is_brk;
      if (complete) begin
        if (!o_vld || i_rdy) begin
          o_vld     <= 1'b1;
          o_data    <= shreg_q;
          pc_pass   <= fin_pc;
          frame_err <= fin_ferr;
        end else begin
          overrun <= 1'b1;
        end
      end else if (o_vld && i_rdy) begin
        o_vld   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 The block SHALL have these parameters:
- DATA_WIDTH, default 8: data bits per frame; legal range 5..9.
- PARITY_CHECK, default "NONE": parity mode; legal values "NONE", "ODD", "EVEN".
- STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
- CLKS_PER_BIT, default 16: clk cycles per bit; legal range 3..1024.

REQ-002 An illegal parameter value SHALL cause $fatal at elaboration.

REQ-003 The block SHALL have these ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial line; idles high.
- i_rdy  in  1  downstream ready.
- o_vld  out  1  frame available.
- o_data  out  DATA_WIDTH  received data, LSB first on the line.
- pc_pass  out  1  parity check passed; valid with o_vld.
- frame_err  out  1  a stop bit was sampled low; valid with o_vld.
- break_det  out  1  one-cycle pulse on a break condition.
- overrun  out  1  sticky flag: a frame was dropped.

Function
REQ-004 rx SHALL pass through a 2-flop synchronizer before use; both flops reset to 1.

REQ-005 Each bit SHALL be decided by majority vote of three synchronized samples taken at bit-counter values MID-1, MID and MID+1, where MID = CLKS_PER_BIT/2 (integer division).

REQ-006 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BRK_WAIT.

REQ-007 IDLE -> START SHALL occur on a synchronized 1->0 transition; this also clears the bit counter.

REQ-008 START -> IDLE SHALL occur when the voted start bit is 1 (glitch): no output, no flags.

REQ-009 START -> DATA SHALL occur when the voted start bit is 0.

REQ-010 DATA SHALL shift in DATA_WIDTH voted bits LSB first, then go to PARITY, or to STOP when PARITY_CHECK="NONE".

REQ-011 PARITY SHALL capture one voted bit, then go to STOP.

REQ-012 STOP SHALL vote STOP_BITS stop bits; the frame completes at the final vote (MID+1 of the last stop bit).

REQ-013 On completion the FSM SHALL go to IDLE, or to BRK_WAIT when a break is detected (REQ-018).

REQ-014 On completion, at the next clock edge:
- o_data, pc_pass and frame_err SHALL load.
- o_vld SHALL rise.

REQ-015 Flag values at completion:
- pc_pass SHALL be 1 for NONE.
- For EVEN, pc_pass SHALL be 1 when the XOR of data bits and parity bit is 0.
- For ODD, pc_pass SHALL be 1 when that XOR is 1.
- frame_err SHALL be 1 if any stop bit voted 0.

REQ-016 Output handshake:
- o_vld SHALL hold until the cycle after o_vld && i_rdy.
- o_data, pc_pass and frame_err SHALL be stable while o_vld=1.

REQ-017 If a frame completes while o_vld=1 and i_rdy=0:
- The new frame SHALL be discarded.
- The held data SHALL be unchanged.
- overrun SHALL be set.
- overrun SHALL clear on the next o_vld && i_rdy handshake.

REQ-018 If completion and handshake occur in the same cycle, the new frame SHALL load, o_vld SHALL stay 1, and overrun SHALL be unchanged.

REQ-019 Break handling:
- A break is all data bits 0, parity bit 0 (if present), and the first stop bit 0.
- On a break, break_det SHALL pulse for one cycle at completion.
- The frame SHALL still be delivered, with frame_err=1.
- The FSM SHALL wait in BRK_WAIT until synchronized rx=1, then go to IDLE.

REQ-020 A falling edge on rx while not in IDLE SHALL be ignored; no resynchronization mid-frame.

REQ-021 Frame latency: from the rx pin falling edge to o_vld=1 SHALL be 3 + (N-1)*CLKS_PER_BIT + MID + 2 cycles, ±1, where N = 1 + DATA_WIDTH + (parity?1:0) + STOP_BITS.

REQ-022 The bit counter SHALL be $clog2(CLKS_PER_BIT) wide and wrap from CLKS_PER_BIT-1 to 0.

Reset
REQ-023 Reset values with rst_n=0:
- o_vld=0, break_det=0, overrun=0, frame_err=0, pc_pass=1, o_data=0.
- FSM=IDLE, counters=0, synchronizer=1.

REQ-024 Assertion of rst_n mid-frame SHALL abort the frame immediately with no output.

REQ-025 After rst_n deasserts, the first valid start edge SHALL be accepted only once synchronized rx has been seen at 1.

Verification
REQ-026 CLKS_PER_BIT=16, 8N1, send 0xA5, i_rdy=1 -> one o_vld pulse with o_data=0xA5, pc_pass=1, frame_err=0, at the REQ-021 latency.

REQ-027 CLKS_PER_BIT=3, EVEN, send 0x3C with parity 0, then 0x3C with parity 1 -> pc_pass 1, then 0; o_data=0x3C both times.

REQ-028 i_rdy=0, send 0x11 then 0x22 -> o_data stays 0x11 and overrun=1. Raise i_rdy -> handshake, then o_vld=0 and overrun=0.

REQ-029 Low pulse of CLKS_PER_BIT/4 cycles on idle rx -> no o_vld and FSM back in IDLE.

REQ-030 8N1, hold rx low for 20 bit times -> o_data=0x00, frame_err=1, one break_det pulse. After rx rises, next frame 0x5A is received correctly.

REQ-031 STOP_BITS=2, second stop bit driven 0, byte 0x81 -> o_data=0x81, frame_err=1.

REQ-032 rst_n pulsed low in the middle of DATA -> o_vld stays 0; the following clean frame 0x7E is received correctly.
